// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: channel FSM state encodings and debounce/long-press cycle derivation
//   btn_state_e : button channel states (IDLE, PRESS_PEND, HELD, REL_PEND)
//   sw_state_e  : switch channel states (STABLE, PEND)
//   cyc_of()    : converts a millisecond interval into clock cycles
package input_conditioner_pkg;

   typedef enum logic [1:0] {
      BTN_IDLE,
      BTN_PRESS_PEND,
      BTN_HELD,
      BTN_REL_PEND
   } btn_state_e;

   typedef enum logic {
      SW_STABLE,
      SW_PEND
   } sw_state_e;

   function automatic int unsigned cyc_of(input int unsigned freq, input int unsigned ms);
      return freq / 1000 * ms;
   endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// debounce_channel: 2-FF synchroniser plus debounce FSM for one raw input
//   clk, rst   : clock, asynchronous active-high reset
//   raw_i      : raw asynchronous pin
//   level_o    : debounced level
//   press_o    : 1-cycle pulse on accepted rise (button press / switch rise)
//   release_o  : 1-cycle pulse on accepted fall (button release / switch fall)
//   long_o     : 1-cycle pulse LONG_CYC cycles after press (button mode only, else 0)
import input_conditioner_pkg::*;

module debounce_channel #(
   parameter int unsigned DB_CYC   = 10,
   parameter int unsigned LONG_CYC = 50,
   parameter bit          HAS_LONG = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);

   localparam int unsigned W = $clog2(LONG_CYC + 1);
   localparam logic [W-1:0] DB = W'(DB_CYC);
   localparam logic [W-1:0] LG = W'(LONG_CYC);

   logic [1:0]   sync_q;
   btn_state_e   bst_q, bst_d;
   sw_state_e    sst_q, sst_d;
   logic [W-1:0] cnt_q, cnt_d, lcnt_q, lcnt_d, cnt_inc, lcnt_inc;
   logic         level_q, level_d, press_q, press_d, release_q, release_d, long_q, long_d;
   logic         s;

   assign s        = sync_q[1];
   assign cnt_inc  = cnt_q + W'(1);
   assign lcnt_inc = lcnt_q + W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= '0;
         bst_q     <= BTN_IDLE;
         sst_q     <= SW_STABLE;
         cnt_q     <= '0;
         lcnt_q    <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], raw_i};
         bst_q     <= bst_d;
         sst_q     <= sst_d;
         cnt_q     <= cnt_d;
         lcnt_q    <= lcnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
      end
   end

   always_comb begin
      bst_d     = bst_q;
      sst_d     = sst_q;
      cnt_d     = cnt_q;
      lcnt_d    = lcnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      if (HAS_LONG) begin
         case (bst_q)
            BTN_IDLE:
               if (s) begin
                  bst_d = BTN_PRESS_PEND;
                  cnt_d = W'(1);
               end
            BTN_PRESS_PEND:
               if (!s) begin
                  bst_d = BTN_IDLE;
                  cnt_d = '0;
               end else if (cnt_inc == DB) begin
                  bst_d   = BTN_HELD;
                  cnt_d   = '0;
                  lcnt_d  = '0;
                  level_d = 1'b1;
                  press_d = 1'b1;
               end else cnt_d = cnt_inc;
            BTN_HELD:
               if (!s) begin
                  bst_d = BTN_REL_PEND;
                  cnt_d = W'(1);
               end else if (lcnt_q != LG) begin
                  // saturation at LG guarantees a single long pulse per press
                  lcnt_d = lcnt_inc;
                  long_d = (lcnt_inc == LG);
               end
            BTN_REL_PEND:
               if (s) begin
                  bst_d = BTN_HELD;
                  cnt_d = '0;
               end else if (cnt_inc == DB) begin
                  bst_d     = BTN_IDLE;
                  cnt_d     = '0;
                  level_d   = 1'b0;
                  release_d = 1'b1;
               end else cnt_d = cnt_inc;
            default: bst_d = BTN_IDLE;
         endcase
      end else begin
         case (sst_q)
            SW_STABLE:
               if (s != level_q) begin
                  sst_d = SW_PEND;
                  cnt_d = W'(1);
               end
            SW_PEND:
               if (s == level_q) begin
                  sst_d = SW_STABLE;
                  cnt_d = '0;
               end else if (cnt_inc == DB) begin
                  sst_d     = SW_STABLE;
                  cnt_d     = '0;
                  level_d   = ~level_q;
                  press_d   = ~level_q;
                  release_d = level_q;
               end else cnt_d = cnt_inc;
            default: sst_d = SW_STABLE;
         endcase
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises, debounces and edge-detects raw buttons and switches
//   clk, rst      : clock, asynchronous active-high reset
//   i_btn_raw     : raw buttons (1 = pressed)
//   i_sw_raw      : raw switches
//   o_btn_level   : debounced button levels
//   o_btn_press   : 1-cycle accepted-press pulses
//   o_btn_release : 1-cycle accepted-release pulses
//   o_btn_long    : 1-cycle long-press pulses, LONG_CYC cycles after press
//   o_sw_level    : debounced switch levels
//   o_sw_change   : 1-cycle accepted-change pulses
import input_conditioner_pkg::*;

module input_conditioner #(
   parameter int unsigned CLK_FREQ    = 100_000_000,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned LONG_MS     = 1000,
   parameter int unsigned N_BTN       = 5,
   parameter int unsigned N_SW        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] i_btn_raw,
   input  logic [N_SW-1:0]  i_sw_raw,
   output logic [N_BTN-1:0] o_btn_level,
   output logic [N_BTN-1:0] o_btn_press,
   output logic [N_BTN-1:0] o_btn_release,
   output logic [N_BTN-1:0] o_btn_long,
   output logic [N_SW-1:0]  o_sw_level,
   output logic [N_SW-1:0]  o_sw_change
);

   localparam int unsigned DB_CYC   = cyc_of(CLK_FREQ, DEBOUNCE_MS);
   localparam int unsigned LONG_CYC = cyc_of(CLK_FREQ, LONG_MS);

   logic [N_SW-1:0] sw_rise, sw_fall, sw_long;

   for (genvar b = 0; b < N_BTN; b++) begin : g_btn
      debounce_channel #(.DB_CYC(DB_CYC), .LONG_CYC(LONG_CYC), .HAS_LONG(1'b1)) u_ch (
         .clk       (clk),
         .rst       (rst),
         .raw_i     (i_btn_raw[b]),
         .level_o   (o_btn_level[b]),
         .press_o   (o_btn_press[b]),
         .release_o (o_btn_release[b]),
         .long_o    (o_btn_long[b])
      );
   end

   for (genvar w = 0; w < N_SW; w++) begin : g_sw
      debounce_channel #(.DB_CYC(DB_CYC), .LONG_CYC(LONG_CYC), .HAS_LONG(1'b0)) u_ch (
         .clk       (clk),
         .rst       (rst),
         .raw_i     (i_sw_raw[w]),
         .level_o   (o_sw_level[w]),
         .press_o   (sw_rise[w]),
         .release_o (sw_fall[w]),
         .long_o    (sw_long[w])
      );
   end

   // sw_long is constant 0 in switch mode; folding it in keeps every channel output consumed
   assign o_sw_change = sw_rise | sw_fall | sw_long;

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed self-checking bench for input_conditioner (DB_CYC=10, LONG_CYC=50)
module tb_input_conditioner;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] btn;
   logic [7:0] sw;
   logic [4:0] btn_level, btn_press, btn_release, btn_long;
   logic [7:0] sw_level, sw_change;

   int passed = 0;
   int total  = 0;
   int press_n[5];
   int rel_n[5];
   int long_n[5];
   int chg_n[8];

   input_conditioner #(
      .CLK_FREQ(10_000), .DEBOUNCE_MS(1), .LONG_MS(5), .N_BTN(5), .N_SW(8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_btn_raw     (btn),
      .i_sw_raw      (sw),
      .o_btn_level   (btn_level),
      .o_btn_press   (btn_press),
      .o_btn_release (btn_release),
      .o_btn_long    (btn_long),
      .o_sw_level    (sw_level),
      .o_sw_change   (sw_change)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      for (int i = 0; i < 5; i++) begin
         if (btn_press[i] === 1'b1) press_n[i]++;
         if (btn_release[i] === 1'b1) rel_n[i]++;
         if (btn_long[i] === 1'b1) long_n[i]++;
      end
      for (int i = 0; i < 8; i++) if (sw_change[i] === 1'b1) chg_n[i]++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_btn_level"}, 32'(btn_level), 32'h0);
      chk({tag, "_btn_press"}, 32'(btn_press), 32'h0);
      chk({tag, "_btn_release"}, 32'(btn_release), 32'h0);
      chk({tag, "_btn_long"}, 32'(btn_long), 32'h0);
      chk({tag, "_sw_level"}, 32'(sw_level), 32'h0);
      chk({tag, "_sw_change"}, 32'(sw_change), 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      btn = '0;
      sw  = '0;
      step(3);
      chk_all_zero("reset");
      rst = 1'b0;
      step(3);
      // 1: clean press, long press, release on btn[0]
      btn[0] = 1'b1;
      step(11);
      chk("t1_press_early", 32'(btn_press), 32'h0);
      chk("t1_level_early", 32'(btn_level), 32'h0);
      step(1);
      chk("t1_press", 32'(btn_press), 32'h01);
      chk("t1_level", 32'(btn_level), 32'h01);
      step(1);
      chk("t1_press_one_cycle", 32'(btn_press), 32'h0);
      step(48);
      chk("t1_long_early", 32'(btn_long), 32'h0);
      step(1);
      chk("t1_long", 32'(btn_long), 32'h01);
      step(1);
      chk("t1_long_one_cycle", 32'(btn_long), 32'h0);
      step(37);
      btn[0] = 1'b0;
      step(11);
      chk("t1_release_early", 32'(btn_release), 32'h0);
      chk("t1_level_held", 32'(btn_level), 32'h01);
      step(1);
      chk("t1_release", 32'(btn_release), 32'h01);
      chk("t1_level_low", 32'(btn_level), 32'h0);
      step(1);
      chk("t1_press_count", press_n[0], 1);
      chk("t1_long_count", long_n[0], 1);
      chk("t1_release_count", rel_n[0], 1);
      // 2: bouncing press on btn[1]
      btn[1] = 1'b1;
      step(5);
      btn[1] = 1'b0;
      step(3);
      btn[1] = 1'b1;
      step(11);
      chk("t2_press_count_early", press_n[1], 0);
      step(1);
      chk("t2_press", 32'(btn_press), 32'h02);
      step(18);
      chk("t2_press_count", press_n[1], 1);
      btn[1] = 1'b0;
      step(15);
      // 3: short release glitch while HELD on btn[2]
      btn[2] = 1'b1;
      step(12);
      chk("t3_press", 32'(btn_press), 32'h04);
      step(20);
      btn[2] = 1'b0;
      step(4);
      btn[2] = 1'b1;
      chk("t3_level_during_dip", 32'(btn_level), 32'h04);
      step(16);
      chk("t3_level_after_dip", 32'(btn_level), 32'h04);
      step(60);
      chk("t3_press_count", press_n[2], 1);
      chk("t3_release_count_held", rel_n[2], 0);
      chk("t3_long_count", long_n[2], 1);
      btn[2] = 1'b0;
      step(15);
      chk("t3_release_count", rel_n[2], 1);
      chk("t3_long_count_final", long_n[2], 1);
      // 4: switch glitch then stable changes on sw[3]
      sw[3] = 1'b1;
      step(6);
      sw[3] = 1'b0;
      step(20);
      chk("t4_glitch_change_count", chg_n[3], 0);
      chk("t4_glitch_level", 32'(sw_level), 32'h0);
      sw[3] = 1'b1;
      step(11);
      chk("t4_change_early", 32'(sw_change), 32'h0);
      step(1);
      chk("t4_change_rise", 32'(sw_change), 32'h08);
      chk("t4_level_high", 32'(sw_level), 32'h08);
      step(1);
      chk("t4_change_one_cycle", 32'(sw_change), 32'h0);
      sw[3] = 1'b0;
      step(12);
      chk("t4_change_fall", 32'(sw_change), 32'h08);
      chk("t4_level_low", 32'(sw_level), 32'h0);
      step(1);
      chk("t4_change_count", chg_n[3], 2);
      // 5: reset mid-debounce with btn[4] held
      btn[4] = 1'b1;
      step(9);
      rst = 1'b1;
      step(2);
      chk_all_zero("t5_in_reset");
      chk("t5_no_press_before_reset", press_n[4], 0);
      rst = 1'b0;
      step(11);
      chk("t5_press_early", 32'(btn_press), 32'h0);
      step(1);
      chk("t5_press", 32'(btn_press), 32'h10);
      step(1);
      chk("t5_press_count", press_n[4], 1);
      btn[4] = 1'b0;
      step(15);
      // 6: all buttons pressed together
      btn = 5'h1f;
      step(12);
      chk("t6_press_all", 32'(btn_press), 32'h1f);
      chk("t6_level_all", 32'(btn_level), 32'h1f);
      step(1);
      chk("t6_press_cleared", 32'(btn_press), 32'h0);
      btn = 5'h00;
      step(12);
      chk("t6_release_all", 32'(btn_release), 32'h1f);
      chk("t6_level_cleared", 32'(btn_level), 32'h0);
      step(1);
      chk("t6_release_cleared", 32'(btn_release), 32'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
